// File: rtl/pdm_tx_pkg.sv
// Shared constants and helpers for the PCM-to-PDM audio transmitter.
package pdm_tx_pkg;

    localparam int DATA_W = 16;

    // All-zero two's complement is the midscale (silent) output level.
    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(0);

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pdm_tx_if.sv
// Valid/ready PCM sample stream into the PDM transmitter.
interface pdm_tx_if #(
    parameter int DATA_W = pdm_tx_pkg::DATA_W
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;

    modport master (output s_tdata, output s_tvalid, input  s_tready);
    modport slave  (input  s_tdata, input  s_tvalid, output s_tready);
endinterface

// File: rtl/pdm_tx_fifo.sv
// Synchronous sample FIFO with occupancy output; a write is never visible on rd_data in the same cycle.
module pdm_tx_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = pdm_tx_pkg::level_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_wr;
    logic              w_rd;

    assign full    = (r_level == LW'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;

    // NOTE: storage has no reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM transmitter: buffered samples feed a first-order sigma-delta modulator driving AUD_PWM.
module pdm_audio_tx #(
    parameter  int DATA_W     = pdm_tx_pkg::DATA_W,
    parameter  int FIFO_DEPTH = 16,
    parameter  int CLK_DIV    = 33,
    parameter  int OSR        = 64,
    localparam int LW         = pdm_tx_pkg::level_w(FIFO_DEPTH)
) (
    input  logic          sysclk,
    input  logic          sysreset_n,
    input  logic          enable,
    pdm_tx_if.slave       s_axis,
    output logic          pdm_out,
    output logic          pdm_strobe,
    output logic          underrun,
    input  logic          clr_underrun,
    output logic [LW-1:0] fifo_level
);
    import pdm_tx_pkg::MIDSCALE;

    localparam int BW = $clog2(CLK_DIV);
    localparam int SW = $clog2(OSR);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OSR - 1);

    logic [BW-1:0]     r_bit_cnt;
    logic [SW-1:0]     r_smp_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_cur_sample;
    logic              r_pdm_out;
    logic              r_pdm_strobe;
    logic              r_underrun;

    logic              w_tick;
    logic              w_load;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_sample;
    logic [DATA_W-1:0] w_u;
    logic [DATA_W:0]   w_sum;

    assign s_axis.s_tready = !w_full;

    pdm_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sysclk),
        .rst_n   (sysreset_n),
        .wr_en   (s_axis.s_tvalid),
        .wr_data (s_axis.s_tdata),
        .rd_en   (w_load),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    assign w_tick   = enable && (r_bit_cnt == BIT_LAST);
    assign w_load   = w_tick && (r_smp_cnt == SMP_LAST);
    assign w_sample = w_load ? (w_empty ? DATA_W'(MIDSCALE) : w_head) : r_cur_sample;
    // Offset binary: flipping the sign bit maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1.
    assign w_u      = {~w_sample[DATA_W-1], w_sample[DATA_W-2:0]};
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_u};

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            r_bit_cnt    <= '0;
            r_smp_cnt    <= SMP_LAST;
            r_acc        <= '0;
            r_cur_sample <= DATA_W'(MIDSCALE);
            r_pdm_out    <= 1'b0;
            r_pdm_strobe <= 1'b0;
        end else if (!enable) begin
            // Parking smp_cnt at its last value makes the first tick after re-enable a load.
            r_bit_cnt    <= '0;
            r_smp_cnt    <= SMP_LAST;
            r_acc        <= '0;
            r_pdm_out    <= 1'b0;
            r_pdm_strobe <= 1'b0;
        end else begin
            r_pdm_strobe <= w_tick;
            if (w_tick) begin
                r_bit_cnt <= '0;
                r_smp_cnt <= (r_smp_cnt == SMP_LAST) ? '0 : r_smp_cnt + SW'(1);
                r_acc     <= w_sum[DATA_W-1:0];
                r_pdm_out <= w_sum[DATA_W];
                if (w_load) r_cur_sample <= w_sample;
            end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    // Setting wins over clearing so an underrun in the clear cycle is not lost.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n)              r_underrun <= 1'b0;
        else if (w_load && w_empty)   r_underrun <= 1'b1;
        else if (clr_underrun)        r_underrun <= 1'b0;
    end

    assign pdm_out    = r_pdm_out;
    assign pdm_strobe = r_pdm_strobe;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Scoreboard bench for pdm_audio_tx: expected PDM bits are queued from an arithmetic model and checked on each strobe.
`timescale 1ns/1ps
module tb_pdm_audio_tx;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int CLK_DIV    = 4;
    localparam int OSR        = 8;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic          sysclk       = 1'b0;
    logic          sysreset_n   = 1'b0;
    logic          enable       = 1'b0;
    logic          clr_underrun = 1'b0;
    logic          pdm_out;
    logic          pdm_strobe;
    logic          underrun;
    logic [LW-1:0] fifo_level;

    pdm_tx_if #(.DATA_W(DATA_W)) s_if ();

    pdm_audio_tx #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV),
        .OSR        (OSR)
    ) dut (
        .sysclk       (sysclk),
        .sysreset_n   (sysreset_n),
        .enable       (enable),
        .s_axis       (s_if),
        .pdm_out      (pdm_out),
        .pdm_strobe   (pdm_strobe),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .fifo_level   (fifo_level)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a PCM value s has density (s + 2^15) / 2^16; each bit is the carry
    // out of an accumulator that adds that amount, starting from zero after every enable.
    bit          exp_q[$];
    bit          rx_bits[$];
    int          m_acc;
    logic [15:0] stim_q[$];

    task automatic model_frame(input logic [15:0] s, input int nbits);
        int u;
        u = int'($signed(s)) + 32768;
        for (int i = 0; i < nbits; i++) begin
            m_acc = m_acc + u;
            exp_q.push_back(m_acc >= 65536);
            if (m_acc >= 65536) m_acc = m_acc - 65536;
        end
    endtask

    // Monitor: every strobe consumes one expected bit; strobes must be CLK_DIV cycles apart.
    int cyc      = 0;
    int last_cyc = -1;
    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (!sysreset_n) begin
            last_cyc = -1;
        end else if (pdm_strobe) begin
            rx_bits.push_back(pdm_out);
            if (exp_q.size() == 0) check("unexpected_strobe", pdm_strobe, 0);
            else                   check("pdm_bit", pdm_out, exp_q.pop_front());
            if (last_cyc >= 0) check("strobe_gap", cyc - last_cyc, CLK_DIV);
            last_cyc = cyc;
        end else if (!enable) begin
            last_cyc = -1;
        end
    end

    // Driver tasks: all are entered and left on a falling edge.
    task automatic write(input logic [15:0] d, output bit accepted);
        s_if.s_tdata  = d;
        s_if.s_tvalid = 1'b1;
        accepted      = s_if.s_tready;
        @(negedge sysclk);
        s_if.s_tvalid = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int seen   = 0;
        int budget = n * CLK_DIV + 20;
        while (seen < n && budget > 0) begin
            @(negedge sysclk);
            budget--;
            if (pdm_strobe) seen++;
        end
        if (seen < n) check("strobe_timeout", seen, n);
    endtask

    task automatic stop_and_check();
        enable = 1'b0;
        @(negedge sysclk);
        check("pdm_out_muted", pdm_out, 0);
        check("strobe_muted", pdm_strobe, 0);
        check("level_drained", fifo_level, 0);
        check("all_bits_seen", exp_q.size(), 0);
        check("no_underrun", underrun, 0);
    endtask

    task automatic drain(input int n);
        enable = 1'b1;
        wait_strobes(1);
        check("level_after_first_tick", fifo_level, n - 1);
        wait_strobes(n * OSR - 1);
        stop_and_check();
    endtask

    task automatic run_samples();
        bit ok;
        m_acc = 0;
        rx_bits.delete();
        foreach (stim_q[i]) begin
            write(stim_q[i], ok);
            check("write_accepted", ok, 1);
            model_frame(stim_q[i], OSR);
        end
        check("level_filled", fifo_level, stim_q.size());
        drain(stim_q.size());
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit          ok;
        int          ones;
        logic [15:0] d;

        s_if.s_tdata  = '0;
        s_if.s_tvalid = 1'b0;

        // Reset state
        repeat (3) @(negedge sysclk);
        check("rst_pdm_out", pdm_out, 0);
        check("rst_s_tready", s_if.s_tready, 1);
        sysreset_n = 1'b1;
        @(negedge sysclk);
        check("idle_pdm_out", pdm_out, 0);
        check("idle_strobe", pdm_strobe, 0);
        check("idle_underrun", underrun, 0);
        check("idle_level", fifo_level, 0);
        check("idle_s_tready", s_if.s_tready, 1);

        // Midscale sample gives alternating bits
        stim_q = {};
        stim_q.push_back(16'h0000);
        run_samples();
        for (int i = 0; i < OSR; i++) check("midscale_pattern", rx_bits[i], i % 2);

        // Full-scale positive then negative
        stim_q = {};
        stim_q.push_back(16'h7FFF);
        stim_q.push_back(16'h8000);
        run_samples();
        ones = 0;
        for (int i = 0; i < OSR; i++) ones += rx_bits[i];
        check("max_frame_ones", ones, OSR - 1);
        ones = 0;
        for (int i = OSR; i < 2 * OSR; i++) ones += rx_bits[i];
        check("min_frame_ones", ones, 0);

        // Fill to full while disabled; the overflow write is refused
        m_acc = 0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            d = 16'($urandom);
            write(d, ok);
            if (i < FIFO_DEPTH) begin
                check("fill_accepted", ok, 1);
                model_frame(d, OSR);
            end else begin
                check("overflow_refused", ok, 0);
            end
            if (i == FIFO_DEPTH - 1) begin
                check("full_level", fifo_level, FIFO_DEPTH);
                check("full_s_tready", s_if.s_tready, 0);
            end
        end
        check("level_after_overflow", fifo_level, FIFO_DEPTH);
        drain(FIFO_DEPTH);

        // Randomized bursts
        repeat (4) begin
            stim_q = {};
            repeat ($urandom_range(1, 5)) stim_q.push_back(16'($urandom));
            run_samples();
        end

        // Underrun: empty FIFO modulates midscale; set beats a same-cycle clear
        clr_underrun = 1'b1;
        @(negedge sysclk);
        clr_underrun = 1'b0;
        check("underrun_clear_idle", underrun, 0);
        m_acc = 0;
        model_frame(16'h0000, 2 * OSR);
        enable = 1'b1;
        wait_strobes(1);
        check("underrun_first_load", underrun, 1);
        wait_strobes(OSR - 1);
        repeat (CLK_DIV - 1) @(negedge sysclk);
        clr_underrun = 1'b1;
        @(negedge sysclk);
        clr_underrun = 1'b0;
        check("strobe_on_second_load", pdm_strobe, 1);
        check("underrun_set_wins", underrun, 1);
        clr_underrun = 1'b1;
        @(negedge sysclk);
        clr_underrun = 1'b0;
        check("underrun_cleared", underrun, 0);
        wait_strobes(OSR - 1);
        stop_and_check();

        // Disable mid-frame, then resume with the next sample
        m_acc = 0;
        d = 16'($urandom);
        write(d, ok);
        check("mid_write_a", ok, 1);
        model_frame(d, 3);
        d = 16'($urandom);
        write(d, ok);
        check("mid_write_b", ok, 1);
        enable = 1'b1;
        wait_strobes(1);
        check("mid_level_after_load", fifo_level, 1);
        wait_strobes(2);
        enable = 1'b0;
        @(negedge sysclk);
        check("mid_pdm_out_muted", pdm_out, 0);
        check("mid_strobe_muted", pdm_strobe, 0);
        check("mid_level_kept", fifo_level, 1);
        ones = 0;
        repeat (5 * CLK_DIV) begin
            @(negedge sysclk);
            ones += pdm_strobe;
        end
        check("mid_no_strobes_disabled", ones, 0);
        m_acc = 0;
        model_frame(d, OSR);
        drain(1);

        // Asynchronous reset in the middle of a stream
        m_acc = 0;
        d = 16'($urandom);
        write(d, ok);
        check("rs_write", ok, 1);
        model_frame(d, OSR);
        model_frame(16'h0000, OSR);
        enable = 1'b1;
        wait_strobes(OSR + 1);
        check("rs_underrun_before", underrun, 1);
        write(16'($urandom), ok);
        write(16'($urandom), ok);
        check("rs_level_before", fifo_level, 2);
        wait_strobes(2);
        #2;
        sysreset_n = 1'b0;
        enable     = 1'b0;
        exp_q.delete();
        #1;
        check("rs_pdm_out", pdm_out, 0);
        check("rs_strobe", pdm_strobe, 0);
        check("rs_s_tready", s_if.s_tready, 1);
        check("rs_level", fifo_level, 0);
        check("rs_underrun", underrun, 0);
        @(negedge sysclk);
        @(negedge sysclk);
        sysreset_n = 1'b1;
        @(negedge sysclk);

        // Normal operation after reset
        stim_q = {};
        stim_q.push_back(16'($urandom));
        stim_q.push_back(16'($urandom));
        run_samples();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
